multicycle_ctrl: RTL and testbench

- Main control FSM for a multicycle RV32I datapath that shares one ALU and one unified memory port across fetch, address generation and writeback.
- Sequences every instruction through fetch/decode/execute/writeback and drives the mux selects and write enables.
- Drives ImmSrc to the immediate extender, combinationally from the opcode.
- Handshakes with memory (req/ready) and traps on illegal opcodes or a memory timeout.

---
 rtl/multicycle_pkg.sv | 65 ++++++
 rtl/mc_instr_decode.sv | 46 ++++
 rtl/multicycle_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared types and encodings for the multicycle RV32I controller
//
// Holds the controller state enum, the RV32I opcodes the controller recognises,
// the mux-select / ALU-op encodings driven to the datapath, trap cause codes and
// the bit positions of the instruction-class one-hot produced by the decoder.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_RST,
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        JAL,
        TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Bit positions in the instruction-class one-hot.
    localparam int CLS_W      = 6;
    localparam int CLS_LOAD   = 0;
    localparam int CLS_STORE  = 1;
    localparam int CLS_RTYPE  = 2;
    localparam int CLS_ITYPE  = 3;
    localparam int CLS_BRANCH = 4;
    localparam int CLS_JAL    = 5;

endpackage

// File: rtl/mc_instr_decode.sv
// rtl/mc_instr_decode.sv - combinational opcode/funct3 classifier for the multicycle controller
//
// Ports:
//   op_i       instruction[6:0]
//   funct3_i   instruction[14:12]
//   imm_src_o  immediate format for the extender (I/S/B/J)
//   cls_o      one-hot instruction class (see CLS_* in multicycle_pkg)
//   illegal_o  no supported class matched
module mc_instr_decode
    import multicycle_pkg::*;
(
    input  logic [6:0]       op_i,
    input  logic [2:0]       funct3_i,
    output logic [1:0]       imm_src_o,
    output logic [CLS_W-1:0] cls_o,
    output logic             illegal_o
);

    always_comb begin
        imm_src_o = IMM_I;
        cls_o     = '0;
        case (op_i)
            OP_LOAD:   cls_o[CLS_LOAD] = 1'b1;
            OP_STORE: begin
                imm_src_o        = IMM_S;
                cls_o[CLS_STORE] = 1'b1;
            end
            OP_RTYPE:  cls_o[CLS_RTYPE] = 1'b1;
            OP_ITYPE:  cls_o[CLS_ITYPE] = 1'b1;
            OP_BRANCH: begin
                // Immediate format follows the opcode even when funct3 is
                // unsupported; only beq/bne count as a legal branch.
                imm_src_o         = IMM_B;
                cls_o[CLS_BRANCH] = (funct3_i == 3'b000) || (funct3_i == 3'b001);
            end
            OP_JAL: begin
                imm_src_o      = IMM_J;
                cls_o[CLS_JAL] = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal_o = ~|cls_o;

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM for a multicycle RV32I datapath
//
// Ports:
//   clk, reset                       clock and asynchronous active-high reset
//   op, funct3, zero                 IR fields and ALU zero flag
//   mem_ready / mem_req, mem_write   unified memory port handshake
//   adr_src, ir_write, pc_write,
//   reg_write                        datapath address select and write strobes
//   imm_src, alu_src_a, alu_src_b,
//   alu_op, result_src               datapath mux selects / ALU control
//   instr_done                       one-cycle retire pulse
//   trap, trap_cause                 sticky fault flag and its cause
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int TIMEOUT_W      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause
);

    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]           dec_imm;
    logic [CLS_W-1:0]     cls;
    logic                 illegal;
    state_t               state_q, state_d;
    logic [1:0]           cause_q, cause_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 timeout;

    mc_instr_decode u_decode (
        .op_i      (op),
        .funct3_i  (funct3),
        .imm_src_o (dec_imm),
        .cls_o     (cls),
        .illegal_o (illegal)
    );

    // Datapath controls are a pure decode of the current state (plus the
    // mem_ready/zero qualifiers on the strobes that need them).
    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        imm_src    = dec_imm;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        instr_done = 1'b0;
        trap       = 1'b0;
        trap_cause = CAUSE_NONE;
        case (state_q)
            S_RST:   imm_src = IMM_I;
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = RES_RDATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
            end
            EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALUOP_FUNCT;
            end
            EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_op     = ALUOP_SUB;
                // funct3[0] selects bne, which takes the branch on non-zero.
                pc_write   = zero ^ funct3[0];
                instr_done = 1'b1;
            end
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            TRAP: begin
                trap       = 1'b1;
                trap_cause = cause_q;
            end
            default: ;
        endcase
    end

    // mem_ready in the final wait cycle beats the watchdog.
    assign timeout = (TIMEOUT_CYCLES != 0) && mem_req && !mem_ready && (wd_q == WD_LAST);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_RST:    state_d = FETCH;
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (illegal) begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else if (cls[CLS_LOAD] || cls[CLS_STORE]) begin
                    state_d = MEMADR;
                end else if (cls[CLS_RTYPE]) begin
                    state_d = EXECR;
                end else if (cls[CLS_ITYPE]) begin
                    state_d = EXECI;
                end else if (cls[CLS_BRANCH]) begin
                    state_d = BRANCH;
                end else begin
                    state_d = JAL;
                end
            end
            MEMADR:   state_d = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mem_ready) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (mem_ready) state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JAL:      state_d = ALUWB;
            TRAP:     state_d = TRAP;
            default:  state_d = S_RST;
        endcase
        if (timeout) begin
            state_d = TRAP;
            cause_d = CAUSE_TIMEOUT;
        end
    end

    // Watchdog counts consecutive stalled cycles within a single state.
    always_comb begin
        if (mem_ready || (state_d != state_q)) begin
            wd_d = '0;
        end else if (mem_req) begin
            wd_d = wd_q + 1'b1;
        end else begin
            wd_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RST;
            cause_q <= CAUSE_NONE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int TMO = 4;
    localparam logic [6:0] ILL_OPS [6] = '{7'b1110011, 7'b0110111, 7'b0010111,
                                           7'b1100111, 7'b0000000, 7'b1111111};

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] imm_src, alu_src_a, alu_src_b, alu_op, result_src;
    logic       instr_done, trap;
    logic [1:0] trap_cause;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] imm_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] alu_op;
        logic [1:0] rsrc;
        logic       done;
        logic       trap;
        logic [1:0] cause;
    } out_t;

    typedef struct {
        string tag;
        logic  rdy;
        logic  zr;
        out_t  exp;
    } step_t;

    out_t       got;
    step_t      q[$];
    int         checks = 0;
    int         errors = 0;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;

    assign got = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  imm_src, alu_src_a, alu_src_b, alu_op, result_src,
                  instr_done, trap, trap_cause};

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_W(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .imm_src    (imm_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .instr_done (instr_done),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got_v, exp_v, $time);
        end
    endtask

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        case (o)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic out_t base();
        out_t e;
        e = '0;
        e.imm_src = imm_of(cur_op);
        return e;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input string tag, input logic rdy, input logic zr, input out_t e);
        step_t s;
        s.tag = tag;
        s.rdy = rdy;
        s.zr  = zr;
        s.exp = e;
        q.push_back(s);
    endtask

    // A memory access that completes after lat stalled cycles unless the
    // watchdog (TMO stalled cycles) fires first.
    task automatic push_mem(input string tag, input int lat, input out_t wait_e,
                            input out_t done_e, output bit to);
        for (int i = 0; i < lat && i < TMO; i++) push({tag, "_wait"}, 1'b0, rbit(), wait_e);
        to = (lat >= TMO);
        if (!to) push(tag, 1'b1, rbit(), done_e);
    endtask

    task automatic push_trap(input logic [1:0] cause);
        out_t e;
        e = base();
        e.trap  = 1'b1;
        e.cause = cause;
        for (int i = 0; i < 3; i++) push("trap", rbit(), rbit(), e);
    endtask

    task automatic push_aluwb();
        out_t e;
        e = base();
        e.reg_write = 1'b1;
        e.done      = 1'b1;
        push("aluwb", rbit(), rbit(), e);
    endtask

    // cls: 0 R, 1 I, 2 load, 3 store, 4 beq, 5 bne, 6 jal, 7 bad opcode, 8 bad branch funct3
    task automatic build(input int cls, input int lf, input int lm, input logic zr_b,
                         output bit trapped);
        out_t w, d, e;
        bit   to;
        trapped = 1'b0;
        cur_f3  = 3'($urandom_range(0, 7));
        case (cls)
            0: cur_op = 7'b0110011;
            1: cur_op = 7'b0010011;
            2: cur_op = 7'b0000011;
            3: cur_op = 7'b0100011;
            4: begin cur_op = 7'b1100011; cur_f3 = 3'b000; end
            5: begin cur_op = 7'b1100011; cur_f3 = 3'b001; end
            6: cur_op = 7'b1101111;
            7: cur_op = ILL_OPS[$urandom_range(0, 5)];
            default: begin cur_op = 7'b1100011; cur_f3 = 3'($urandom_range(2, 7)); end
        endcase
        q.delete();
        w = base();
        w.mem_req = 1'b1;
        w.b       = 2'b10;
        w.rsrc    = 2'b10;
        d = w;
        d.ir_write = 1'b1;
        d.pc_write = 1'b1;
        push_mem("fetch", lf, w, d, to);
        if (to) begin
            push_trap(2'b10);
            trapped = 1'b1;
        end else begin
            e = base();
            e.a = 2'b01;
            e.b = 2'b01;
            push("decode", rbit(), rbit(), e);
            case (cls)
                0, 1: begin
                    e = base();
                    e.a      = 2'b10;
                    e.b      = (cls == 0) ? 2'b00 : 2'b01;
                    e.alu_op = 2'b10;
                    push("exec", rbit(), rbit(), e);
                    push_aluwb();
                end
                2, 3: begin
                    e = base();
                    e.a = 2'b10;
                    e.b = 2'b01;
                    push("memadr", rbit(), rbit(), e);
                    w = base();
                    w.mem_req   = 1'b1;
                    w.adr_src   = 1'b1;
                    w.mem_write = (cls == 3);
                    d = w;
                    d.done = (cls == 3);
                    push_mem((cls == 2) ? "memread" : "memwrite", lm, w, d, to);
                    if (to) begin
                        push_trap(2'b10);
                        trapped = 1'b1;
                    end else if (cls == 2) begin
                        e = base();
                        e.rsrc      = 2'b01;
                        e.reg_write = 1'b1;
                        e.done      = 1'b1;
                        push("memwb", rbit(), rbit(), e);
                    end
                end
                4, 5: begin
                    e = base();
                    e.a        = 2'b10;
                    e.alu_op   = 2'b01;
                    e.done     = 1'b1;
                    e.pc_write = zr_b ^ cur_f3[0];
                    push("branch", rbit(), zr_b, e);
                end
                6: begin
                    e = base();
                    e.a        = 2'b01;
                    e.b        = 2'b10;
                    e.pc_write = 1'b1;
                    push("jal", rbit(), rbit(), e);
                    push_aluwb();
                end
                default: begin
                    push_trap(2'b01);
                    trapped = 1'b1;
                end
            endcase
        end
    endtask

    task automatic run_q();
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                op     = cur_op;
                funct3 = cur_f3;
            end
            mem_ready = q[i].rdy;
            zero      = q[i].zr;
            #1;
            check(q[i].tag, 32'(got), 32'(q[i].exp));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        op        = 7'b0110011;
        mem_ready = 1'b0;
        #1;
        check("reset_hold", 32'(got), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_release", 32'(got), 32'd0);
    endtask

    task automatic do_instr(input int cls, input int lf, input int lm, input logic zr_b);
        bit trapped;
        build(cls, lf, lm, zr_b, trapped);
        run_q();
        if (trapped) do_reset();
    endtask

    initial begin
        bit tr;
        reset     = 1'b1;
        op        = 7'b0110011;
        funct3    = 3'b000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        do_reset();

        do_instr(0, 0, 0, 1'b0);
        do_instr(2, 0, 3, 1'b0);
        do_instr(4, 0, 0, 1'b1);
        do_instr(4, 0, 0, 1'b0);
        do_instr(5, 1, 0, 1'b1);
        do_instr(5, 0, 0, 1'b0);
        do_instr(6, 2, 0, 1'b0);
        do_instr(3, 0, 1, 1'b0);
        do_instr(7, 0, 0, 1'b0);
        do_instr(0, 4, 0, 1'b0);
        do_instr(0, 3, 0, 1'b0);
        do_instr(8, 0, 0, 1'b0);

        // Abort a store while it waits for memory: the write strobe must
        // drop as soon as reset rises, without waiting for a clock edge.
        build(3, 0, 3, 1'b0, tr);
        void'(q.pop_back());
        void'(q.pop_back());
        run_q();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 32'(got), 32'd0);
        do_reset();

        for (int n = 0; n < 160; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            do_instr(int'($urandom_range(0, 8)), (r < 8) ? r % 4 : 4,
                     int'($urandom_range(0, 4)), rbit());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
